// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from N_REQ byte requesters.
// Optional WAIT-state timeout with err pulse when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int START_HOLD  = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     ack,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    output logic [2:0]           gnt_id,
    output logic                 busy,
    output logic                 err
);

    localparam int HOLD_W = $clog2(START_HOLD);

    generate
        if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
            $error("uart_tx_arbiter: N_REQ must be 2..8");
        end
        if (START_HOLD < 3) begin : g_bad_hold
            $error("uart_tx_arbiter: START_HOLD must be >= 3");
        end
        if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
            $error("uart_tx_arbiter: TIMEOUT_CYC must fit 16 bits");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t              state_reg, state_next;
    logic [2:0]          rr_ptr_reg, rr_ptr_next;
    logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
    logic [7:0]          tx_data_reg, tx_data_next;
    logic [2:0]          gnt_id_reg, gnt_id_next;
    logic [N_REQ-1:0]    ack_reg, ack_next;
    logic                tx_start_reg, tx_start_next;
    logic                busy_reg, busy_next;
    logic                err_reg, err_next;
    logic                tx_done_q_reg;
    logic                done_rise;

    logic [7:0]          req_byte [N_REQ];
    logic [2:0]          cand_idx [N_REQ];
    logic [N_REQ-1:0]    cand_req;
    logic [N_REQ-1:0]    gnt_onehot;
    logic [2:0]          sel_id;
    logic                sel_valid;
    logic [7:0]          sel_byte;
    logic [2:0]          next_ptr;

    // Candidate k is the requester k positions after rr_ptr, wrapped into 0..N_REQ-1.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [3:0] sum_w;
            assign req_byte[gi]   = req_data[8*gi +: 8];
            assign sum_w          = {1'b0, rr_ptr_reg} + 4'(gi);
            assign cand_idx[gi]   = (sum_w >= 4'(N_REQ)) ? 3'(sum_w - 4'(N_REQ)) : sum_w[2:0];
            assign cand_req[gi]   = |(req & (N_REQ'(1) << cand_idx[gi]));
            assign gnt_onehot[gi] = (gnt_id_reg == 3'(gi));
        end
    endgenerate

    // Descending scan so the candidate closest to rr_ptr wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = rr_ptr_reg;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                sel_valid = 1'b1;
                sel_id    = cand_idx[k];
            end
        end
    end

    always_comb begin
        sel_byte = 8'h00;
        for (int k = 0; k < N_REQ; k++) begin
            if (sel_id == 3'(k)) begin
                sel_byte = req_byte[k];
            end
        end
    end

    assign next_ptr  = (gnt_id_reg == 3'(N_REQ - 1)) ? 3'd0 : gnt_id_reg + 3'd1;
    assign done_rise = tx_done & ~tx_done_q_reg;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] wait_cnt_reg, wait_cnt_next;
`endif

    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        hold_cnt_next = hold_cnt_reg;
        tx_data_next  = tx_data_reg;
        gnt_id_next   = gnt_id_reg;
        ack_next      = '0;
        err_next      = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        wait_cnt_next = wait_cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (sel_valid) begin
                    gnt_id_next   = sel_id;
                    tx_data_next  = sel_byte;
                    hold_cnt_next = '0;
                    state_next    = START;
                end
            end
            START: begin
                if (hold_cnt_reg == HOLD_W'(START_HOLD - 1)) begin
                    state_next = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                    wait_cnt_next = 16'd0;
`endif
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            WAIT: begin
                if (done_rise) begin
                    state_next = DONE;
                    ack_next   = gnt_onehot;
`ifdef UART_ARB_TIMEOUT_EN
                end else if (wait_cnt_reg == 16'(TIMEOUT_CYC - 1)) begin
                    // Abandon the frame: no ack, but still advance fairness.
                    err_next    = 1'b1;
                    rr_ptr_next = next_ptr;
                    state_next  = IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 16'd1;
`endif
                end
            end
            DONE: begin
                rr_ptr_next = next_ptr;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
        tx_start_next = (state_next == START);
        busy_next     = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= 3'd0;
            hold_cnt_reg  <= '0;
            tx_data_reg   <= 8'h00;
            gnt_id_reg    <= 3'd0;
            ack_reg       <= '0;
            tx_start_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
            tx_done_q_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            hold_cnt_reg  <= hold_cnt_next;
            tx_data_reg   <= tx_data_next;
            gnt_id_reg    <= gnt_id_next;
            ack_reg       <= ack_next;
            tx_start_reg  <= tx_start_next;
            busy_reg      <= busy_next;
            err_reg       <= err_next;
            tx_done_q_reg <= tx_done;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg <= 16'd0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end
`endif

    assign ack      = ack_reg;
    assign tx_start = tx_start_reg;
    assign tx_data  = tx_data_reg;
    assign gnt_id   = gnt_id_reg;
    assign busy     = busy_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single frame, round-robin contention,
// data hold, stray done edge, mid-frame reset and (with the macro) timeout.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int SH = 4;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 65535;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   ack;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_done;
    logic [2:0]     gnt_id;
    logic           busy;
    logic           err;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_arbiter #(
        .N_REQ      (N),
        .START_HOLD (SH),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_data(req_data),
        .ack     (ack),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx_done (tx_done),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Call in the cycle the request is presented; returns in the IDLE cycle after DONE.
    task automatic serve(input int id, input logic [7:0] data, input bit stray,
                         input bit poke, input logic [N-1:0] req_after);
        logic [N-1:0] exp_ack;
        exp_ack = 4'b0001 << id;
        tick(1);
        chk("start_busy", 32'(busy), 1);
        chk("gnt_id", 32'(gnt_id), 32'(id));
        chk("tx_data", 32'(tx_data), 32'(data));
        chk("tx_start_1", 32'(tx_start), 1);
        if (stray) tx_done = 1'b1;
        for (int c = 2; c <= SH; c++) begin
            tick(1);
            chk($sformatf("tx_start_%0d", c), 32'(tx_start), 1);
            chk("ack_in_start", 32'(ack), 0);
        end
        tick(1);
        chk("tx_start_wait", 32'(tx_start), 0);
        chk("wait_busy", 32'(busy), 1);
        chk("ack_in_wait", 32'(ack), 0);
        if (stray) begin
            tick(1);
            chk("stray_busy", 32'(busy), 1);
            chk("stray_ack", 32'(ack), 0);
            tx_done = 1'b0;
            tick(1);
            chk("stray_still_wait", 32'(busy), 1);
            chk("stray_ack2", 32'(ack), 0);
        end
        if (poke) begin
            req_data[8*id +: 8] = 8'hFF;
            for (int c = 0; c < 3; c++) begin
                tick(1);
                chk("hold_tx_data", 32'(tx_data), 32'(data));
            end
        end
        tx_done = 1'b1;
        tick(1);
        chk("ack_pulse", 32'(ack), 32'(exp_ack));
        chk("done_tx_data", 32'(tx_data), 32'(data));
        chk("done_busy", 32'(busy), 1);
        req = req_after;
        tx_done = 1'b0;
        tick(1);
        chk("ack_cleared", 32'(ack), 0);
        chk("idle_busy", 32'(busy), 0);
        $display("frame id=%0d data=%02h stray=%0d poke=%0d done", id, data, stray, poke);
    endtask

    initial begin
        rst      = 1'b1;
        req      = '0;
        tx_done  = 1'b0;
        req_data = {8'hD4, 8'hA5, 8'h3C, 8'h11};
        tick(3);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_gnt_id", 32'(gnt_id), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;
        tick(1);

        // Single requester 2
        req = 4'b0100;
        serve(2, 8'hA5, 1'b0, 1'b0, 4'b0000);

        // Contention from a fresh rr_ptr=0
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        req = 4'b1111;
        serve(0, 8'h11, 1'b0, 1'b0, 4'b1111);
        serve(1, 8'h3C, 1'b0, 1'b0, 4'b1111);
        serve(2, 8'hA5, 1'b0, 1'b0, 4'b1111);
        serve(3, 8'hD4, 1'b0, 1'b0, 4'b1111);
        serve(0, 8'h11, 1'b0, 1'b0, 4'b0000);

        // Data hold on requester 1
        req = 4'b0010;
        serve(1, 8'h3C, 1'b0, 1'b1, 4'b0000);
        req_data[15:8] = 8'h3C;

        // Stray tx_done during START
        req = 4'b0100;
        serve(2, 8'hA5, 1'b1, 1'b0, 4'b0000);

        // Reset in WAIT for requester 3
        req = 4'b1000;
        tick(SH + 1);
        chk("pre_rst_busy", 32'(busy), 1);
        chk("pre_rst_gnt", 32'(gnt_id), 3);
        rst = 1'b1;
        req = 4'b0000;
        tick(1);
        chk("mid_rst_tx_start", 32'(tx_start), 0);
        chk("mid_rst_tx_data", 32'(tx_data), 0);
        chk("mid_rst_gnt_id", 32'(gnt_id), 0);
        chk("mid_rst_ack", 32'(ack), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_err", 32'(err), 0);
        rst = 1'b0;
        tx_done = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(1);
            chk("post_rst_no_ack", 32'(ack), 0);
            chk("post_rst_idle", 32'(busy), 0);
        end
        tx_done = 1'b0;
        tick(1);
        req = 4'b1001;
        serve(0, 8'h11, 1'b0, 1'b0, 4'b1000);
        serve(3, 8'hD4, 1'b0, 1'b0, 4'b0000);

`ifdef UART_ARB_TIMEOUT_EN
        // Timeout: WAIT entered SH+1 cycles after request, err TO cycles later
        req = 4'b0010;
        tick(SH + 1);
        chk("to_wait_entry", 32'(busy), 1);
        chk("to_gnt", 32'(gnt_id), 1);
        tick(TO - 1);
        chk("to_no_err_yet", 32'(err), 0);
        chk("to_still_busy", 32'(busy), 1);
        tick(1);
        chk("to_err_pulse", 32'(err), 1);
        chk("to_no_ack", 32'(ack), 0);
        chk("to_idle", 32'(busy), 0);
        req = 4'b0111;
        tick(1);
        chk("to_err_cleared", 32'(err), 0);
        chk("to_regrant_gnt", 32'(gnt_id), 2);
        chk("to_regrant_busy", 32'(busy), 1);
        $display("timeout frame id=1 err observed after %0d wait cycles", TO);
        rst = 1'b1;
        req = 4'b0000;
        tick(1);
        rst = 1'b0;
        tick(1);
`else
        chk("err_tied_low", 32'(err), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
